// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dmem arbiter: width defaults and the FSM
// state encoding, chosen so each grant output is a single state bit.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // One-hot grant states; IDLE is all zeros so both grants are low.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  function automatic arb_state_e state_from_pick(input logic [1:0] pick);
    if (pick[0]) return GNT0;
    if (pick[1]) return GNT1;
    return IDLE;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two dmem ports; ptr = 1 favours
// p1 on a simultaneous request, ptr = 0 favours p0.
module dmem_arb_pick (
  input  logic [1:0] reqs,
  input  logic       ptr,
  output logic [1:0] pick
);

  always_comb begin
    if (reqs == 2'b11) pick = ptr ? 2'b10 : 2'b01;
    else               pick = reqs;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous dmem; one access per cycle.
// Define DMEM_ARB_RR_EN for round-robin on conflicts, otherwise p0 always wins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_wren,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_wren,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
);

  arb_state_e        state_q, state_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ptr;
  logic [1:0]        pick;

  dmem_arb_pick u_pick (
    .reqs ({p1_req, p0_req}),
    .ptr  (ptr),
    .pick (pick)
  );

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Point at the loser of the grant being registered this edge.
  always_comb begin
    ptr_d = ptr_q;
    if (pick[0])      ptr_d = 1'b1;
    else if (pick[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    state_d      = state_from_pick(pick);
    dmem_address = '0;
    dmem_data    = '0;
    dmem_wren    = 1'b0;
    rvalid_d     = '0;
    case (state_q)
      GNT0: begin
        dmem_address = p0_addr;
        dmem_data    = p0_wdata;
        dmem_wren    = p0_wren & p0_req;
        rvalid_d[0]  = ~p0_wren & p0_req;
      end
      GNT1: begin
        dmem_address = p1_addr;
        dmem_data    = p1_wdata;
        dmem_wren    = p1_wren & p1_req;
        rvalid_d[1]  = ~p1_wren & p1_req;
      end
      default: ;
    endcase
    // dmem_q is only meaningful in the rvalid cycle; otherwise replay the last read.
    rdata_d = (|rvalid_q) ? dmem_q : rdata_q;
  end

  // NOTE: state is cleared by the asynchronous reset and updated with
  // non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign p0_gnt    = state_q[0];
  assign p1_gnt    = state_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign rdata     = rdata_d;

endmodule
